ldpc_decode_scheduler: RTL and testbench

//  Sequences the circulant memory fetcher through one LDPC decode: per iteration a variable-to-check (VR)

---
 rtl/ldpc_decode_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_ldpc_decode_scheduler.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_decode_scheduler.sv
// LDPC decode scheduler: sequences VR and CN sweeps over the circulant nodes,
// runs the syndrome check, and counts iterations until pass, limit or abort.
module ldpc_decode_scheduler #(
    parameter int unsigned LOG2CIRC_SIZE = 2,
    parameter int unsigned PIPE_DEPTH    = 2,
    parameter int unsigned ITER_W        = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ITER_W-1:0]        max_iter,
    input  logic                     syn_valid,
    input  logic                     syn_ok,
    output logic                     syn_req,
    output logic                     vr_process,
    output logic                     cn_process,
    output logic [LOG2CIRC_SIZE-1:0] circ_node,
    output logic                     fetch_valid,
    output logic                     wr_en,
    output logic [LOG2CIRC_SIZE-1:0] wr_node,
    output logic [ITER_W-1:0]        iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     success
);

    localparam int unsigned CIRC_SIZE = 2 ** LOG2CIRC_SIZE;
    localparam int unsigned DRAIN_W   = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [LOG2CIRC_SIZE-1:0] LAST_NODE  = LOG2CIRC_SIZE'(CIRC_SIZE - 1);
    localparam logic [DRAIN_W-1:0]       LAST_DRAIN = DRAIN_W'(PIPE_DEPTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StVr,
        StVrDrain,
        StCn,
        StCnDrain,
        StCheck,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [LOG2CIRC_SIZE-1:0] node_q, node_d;
    logic [DRAIN_W-1:0]       drain_q, drain_d;
    logic [ITER_W-1:0]        iter_q, iter_d;
    logic [ITER_W-1:0]        max_q, max_d;
    logic                     success_q, success_d;
    logic                     syn_req_q, syn_req_d;

    // Write-back delay line: one stage per cycle of fetch-to-write latency.
    logic [PIPE_DEPTH-1:0]    vpipe_q;
    logic [LOG2CIRC_SIZE-1:0] npipe_q [PIPE_DEPTH];

    // Next-state logic: abort overrides everything, otherwise walk the sweep sequence.
    always_comb begin
        state_d   = state_q;
        node_d    = node_q;
        drain_d   = drain_q;
        iter_d    = iter_q;
        max_d     = max_q;
        success_d = success_q;
        if (abort) begin
            state_d = StIdle;
            node_d  = '0;
            drain_d = '0;
            if (state_q != StIdle) begin
                success_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d   = StVr;
                        node_d    = '0;
                        drain_d   = '0;
                        iter_d    = '0;
                        success_d = 1'b0;
                        // A zero limit still runs one iteration.
                        max_d     = (max_iter == '0) ? ITER_W'(1) : max_iter;
                    end
                end
                StVr: begin
                    node_d = node_q + 1'b1;
                    if (node_q == LAST_NODE) begin
                        state_d = StVrDrain;
                    end
                end
                StVrDrain: begin
                    if (drain_q == LAST_DRAIN) begin
                        drain_d = '0;
                        state_d = StCn;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                StCn: begin
                    node_d = node_q + 1'b1;
                    if (node_q == LAST_NODE) begin
                        state_d = StCnDrain;
                    end
                end
                StCnDrain: begin
                    if (drain_q == LAST_DRAIN) begin
                        drain_d = '0;
                        state_d = StCheck;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
                StCheck: begin
                    if (syn_valid) begin
                        if (syn_ok) begin
                            state_d   = StDone;
                            success_d = 1'b1;
                        end else if (iter_q == max_q - 1'b1) begin
                            state_d   = StDone;
                            success_d = 1'b0;
                        end else begin
                            iter_d  = iter_q + 1'b1;
                            state_d = StVr;
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
        syn_req_d = (state_d == StCheck) && (state_q != StCheck);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            node_q    <= '0;
            drain_q   <= '0;
            iter_q    <= '0;
            max_q     <= '0;
            success_q <= 1'b0;
            syn_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            node_q    <= node_d;
            drain_q   <= drain_d;
            iter_q    <= iter_d;
            max_q     <= max_d;
            success_q <= success_d;
            syn_req_q <= syn_req_d;
        end
    end

    // Write-back delay line, flushed on abort so no stale write escapes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q <= '0;
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                npipe_q[i] <= '0;
            end
        end else if (abort) begin
            vpipe_q <= '0;
            for (int i = 0; i < int'(PIPE_DEPTH); i++) begin
                npipe_q[i] <= '0;
            end
        end else begin
            vpipe_q[0] <= fetch_valid;
            npipe_q[0] <= circ_node;
            for (int i = 1; i < int'(PIPE_DEPTH); i++) begin
                vpipe_q[i] <= vpipe_q[i-1];
                npipe_q[i] <= npipe_q[i-1];
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy        = (state_q != StIdle);
        vr_process  = (state_q == StVr) || (state_q == StVrDrain);
        cn_process  = (state_q == StCn) || (state_q == StCnDrain);
        fetch_valid = (state_q == StVr) || (state_q == StCn);
        circ_node   = node_q;
        done        = (state_q == StDone);
        syn_req     = syn_req_q;
        wr_en       = vpipe_q[PIPE_DEPTH-1];
        wr_node     = npipe_q[PIPE_DEPTH-1];
        iter_count  = iter_q;
        success     = success_q;
    end

endmodule

// File: tb/tb_ldpc_decode_scheduler.sv
// Randomized self-checking bench for ldpc_decode_scheduler. The expected
// cycle-by-cycle behaviour is computed from the sweep timing arithmetic.
module tb_ldpc_decode_scheduler;

    localparam int C      = 4;
    localparam int P      = 2;
    localparam int S      = C + P;
    localparam int ITER_W = 6;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ITER_W-1:0] max_iter;
    logic              syn_valid;
    logic              syn_ok;
    logic              syn_req;
    logic              vr_process;
    logic              cn_process;
    logic [1:0]        circ_node;
    logic              fetch_valid;
    logic              wr_en;
    logic [1:0]        wr_node;
    logic [ITER_W-1:0] iter_count;
    logic              busy;
    logic              done;
    logic              success;

    int n_checks;
    int n_errors;

    ldpc_decode_scheduler #(
        .LOG2CIRC_SIZE(2),
        .PIPE_DEPTH   (P),
        .ITER_W       (ITER_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .max_iter   (max_iter),
        .syn_valid  (syn_valid),
        .syn_ok     (syn_ok),
        .syn_req    (syn_req),
        .vr_process (vr_process),
        .cn_process (cn_process),
        .circ_node  (circ_node),
        .fetch_valid(fetch_valid),
        .wr_en      (wr_en),
        .wr_node    (wr_node),
        .iter_count (iter_count),
        .busy       (busy),
        .done       (done),
        .success    (success)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string w, input int vr, input int cn, input int fv,
                             input int node, input int wr, input int wnode, input int req,
                             input int bsy, input int dn, input int it, input int suc);
        check_eq({w, ".vr_process"},  32'(vr_process),  32'(vr));
        check_eq({w, ".cn_process"},  32'(cn_process),  32'(cn));
        check_eq({w, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
        check_eq({w, ".circ_node"},   32'(circ_node),   32'(node));
        check_eq({w, ".wr_en"},       32'(wr_en),       32'(wr));
        check_eq({w, ".wr_node"},     32'(wr_node),     32'(wnode));
        check_eq({w, ".syn_req"},     32'(syn_req),     32'(req));
        check_eq({w, ".busy"},        32'(busy),        32'(bsy));
        check_eq({w, ".done"},        32'(done),        32'(dn));
        check_eq({w, ".iter_count"},  32'(iter_count),  32'(it));
        check_eq({w, ".success"},     32'(success),     32'(suc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_abort(input int it);
        abort = 1'b1;
        start = 1'($urandom % 2);
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_all("abort", 0, 0, 0, 0, 0, 0, 0, 0, 0, it, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("abort_no_done", 32'(done), 32'd0);
            check_eq("abort_idle", 32'(busy), 32'd0);
        end
    endtask

    // One decode: ok_pat bit i is the syndrome verdict at CHECK of iteration i.
    task automatic run_decode(input int mi, input int ok_pat, input int wait_fix,
                              input int abort_at, input bit rst_in_check);
        int eff;
        int cyc;
        int w;
        int u;
        int cnp;
        bit ok;
        eff      = (mi == 0) ? 1 : mi;
        start    = 1'b1;
        max_iter = ITER_W'(mi);
        tick();
        start = 1'b0;
        cyc   = 1;
        for (int it = 0; it < eff; it++) begin
            for (int t = 0; t < 2 * S; t++) begin
                u   = t % S;
                cnp = (t >= S) ? 1 : 0;
                check_all("sweep", 1 - cnp, cnp, (u < C) ? 1 : 0, (u < C) ? u : 0,
                          (u >= P) ? 1 : 0, (u >= P) ? u - P : 0, 0, 1, 0, it, 0);
                if (cyc == abort_at) begin
                    do_abort(it);
                    return;
                end
                start    = ($urandom % 5 == 0);
                max_iter = ITER_W'($urandom);
                tick();
                cyc++;
            end
            start = 1'b0;
            w     = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
            ok    = ok_pat[it];
            for (int k = 0; k <= w; k++) begin
                check_all("check", 0, 0, 0, 0, 0, 0, (k == 0) ? 1 : 0, 1, 0, it, 0);
                if (rst_in_check && k == w) begin
                    rst_n = 1'b0;
                    #1;
                    check_all("reset_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    #1 rst_n = 1'b1;
                    tick();
                    check_all("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                    return;
                end
                if (cyc == abort_at) begin
                    do_abort(it);
                    return;
                end
                syn_valid = (k == w) && !rst_in_check;
                syn_ok    = (k == w) ? ok : 1'($urandom % 2);
                tick();
                cyc++;
            end
            syn_valid = 1'b0;
            syn_ok    = 1'b0;
            if (ok || it == eff - 1) begin
                check_all("done", 0, 0, 0, 0, 0, 0, 0, 1, 1, it, ok ? 1 : 0);
                start    = 1'b1;
                max_iter = ITER_W'($urandom);
                tick();
                start = 1'b0;
                check_all("after_done", 0, 0, 0, 0, 0, 0, 0, 0, 0, it, ok ? 1 : 0);
                return;
            end
        end
    endtask

    initial begin
        int mi;
        int ab;
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        max_iter  = '0;
        syn_valid = 1'b0;
        syn_ok    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Start and abort together in idle: abort wins.
        start    = 1'b1;
        abort    = 1'b1;
        max_iter = ITER_W'(3);
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_all("start_abort_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_eq("start_abort_idle2.busy", 32'(busy), 32'd0);

        run_decode(3, 1, 0, -1, 0);          // pass at first CHECK
        run_decode(3, 0, -1, -1, 0);         // runs out of iterations
        run_decode(0, 0, 1, -1, 0);          // zero limit behaves as one
        run_decode(2, 0, 0, 1 + S + 1, 0);   // abort on 2nd CN fetch
        run_decode(1, 0, 20, -1, 1);         // long CHECK wait, then reset

        for (int n = 0; n < 40; n++) begin
            mi = int'($urandom_range(0, 4));
            ab = ($urandom % 4 == 0) ? int'($urandom_range(1, 40)) : -1;
            run_decode(mi, int'($urandom), -1, ab, 0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                check_eq("idle_gap.busy", 32'(busy), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
